// File: rtl/rr_grant_pkg.sv
// rtl/rr_grant_pkg.sv - shared types and circular priority pick for rr_grant_ctrl
//
// Contents:
//   MAX_BITS / MAX_N : widest requester index the pick function supports
//   state_t          : arbiter FSM encoding (IDLE=0, GRANT=1)
//   pick_t           : result of a circular priority search (found, idx)
//   rr_pick()        : first set request bit searching ptr, ptr+1, ... mod n

package rr_grant_pkg;

  localparam int MAX_BITS = 8;
  localparam int MAX_N    = 1 << MAX_BITS;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_BITS-1:0] idx;
  } pick_t;

  // Callers pad req/ptr up to MAX_N/MAX_BITS; n (a power of two) bounds
  // the search so padded request bits are never considered.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0]    req,
                                    input logic [MAX_BITS-1:0] ptr,
                                    input int                  n);
    pick_t               res;
    logic [MAX_BITS-1:0] cand;
    res = '0;
    for (int k = 0; k < MAX_N; k++) begin
      cand = MAX_BITS'((int'(ptr) + k) & (n - 1));
      if (k < n && !res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_grant_ctrl_decoder.sv
// rtl/rr_grant_ctrl_decoder.sv - binary-to-one-hot decoder with enable
//
// Ports:
//   idx_i    : binary index
//   en_i     : when low the output is all zero
//   onehot_o : one-hot decode of idx_i, gated by en_i

module rr_grant_ctrl_decoder #(
  parameter int BITS = 3
) (
  input  logic [BITS-1:0]      idx_i,
  input  logic                 en_i,
  output logic [(1<<BITS)-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// rtl/rr_grant_ctrl.sv - round-robin arbiter with tenure hold and one dead cycle
//
// Optional feature macro: RR_GRANT_TIMEOUT_EN (bounded tenure, preempt pulse).
//
// Ports:
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset
//   req         : per-requester request level (N = 1<<BITS bits)
//   grant       : registered one-hot grant, zero when no owner
//   grant_idx   : binary index of the owner, valid while grant_valid
//   grant_valid : high while an owner holds the resource
//   preempt     : one-cycle pulse in the IDLE cycle after a timeout release

module rr_grant_ctrl
  import rr_grant_pkg::*;
#(
  parameter int BITS     = 3,
  parameter int HOLD_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [(1<<BITS)-1:0] req,
  output logic [(1<<BITS)-1:0] grant,
  output logic [BITS-1:0]      grant_idx,
  output logic                 grant_valid,
  output logic                 preempt
);

  localparam int N = 1 << BITS;

  state_t          state_q;
  logic [BITS-1:0] ptr_q;
  logic [BITS-1:0] idx_q;
  logic            valid_q;
  logic            preempt_q;

  pick_t           pick;
  logic            unused_pick_hi;

  assign pick           = rr_pick(MAX_N'(req), MAX_BITS'(ptr_q), N);
  // Only the low BITS of the padded index are meaningful here.
  assign unused_pick_hi = ^pick.idx;

`ifdef RR_GRANT_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       others_req;

  assign others_req = |(req & ~grant);
`else
  localparam int unused_hold_max = HOLD_MAX;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick.found) begin
            state_q <= ST_GRANT;
            idx_q   <= pick.idx[BITS-1:0];
            valid_q <= 1'b1;
`ifdef RR_GRANT_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (!req[idx_q]) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ptr_q   <= idx_q + BITS'(1);
`ifdef RR_GRANT_TIMEOUT_EN
          // cnt_q counts grant cycles already completed before this one,
          // so HOLD_MAX-1 here means the owner has now held HOLD_MAX cycles.
          end else if (cnt_q >= 8'(HOLD_MAX - 1) && others_req) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            ptr_q     <= idx_q + BITS'(1);
            preempt_q <= 1'b1;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
      endcase
    end
  end

  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign preempt     = preempt_q;

  rr_grant_ctrl_decoder #(
    .BITS (BITS)
  ) u_decoder (
    .idx_i    (idx_q),
    .en_i     (valid_q),
    .onehot_o (grant)
  );

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb/tb_rr_grant_ctrl.sv - directed self-checking bench for rr_grant_ctrl (BITS=2)

module tb_rr_grant_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  int n_tests = 0;
  int n_fail  = 0;

  rr_grant_ctrl #(
    .BITS     (2),
    .HOLD_MAX (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] idx,
                           input logic v, input logic p);
    check({tag, ".grant"},   32'(grant),       32'(g));
    check({tag, ".valid"},   32'(grant_valid), 32'(v));
    if (v) check({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    check({tag, ".preempt"}, 32'(preempt),     32'(p));
  endtask

  logic [3:0] rot_seq [4];
  logic [1:0] rot_idx [4];
  logic [3:0] cur;
  bit         hold_ok;

  initial begin
    rot_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_idx = '{2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held two cycles with all requesting
    rst = 1'b1;
    req = 4'b1111;
    tick();
    check_all("rst_c1", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("rst_c1.idx", 32'(grant_idx), 32'd0);
    tick();
    check_all("rst_c2", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_all("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Rotation: each owner holds 3 cycles, drops, then re-raises
    cur = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rot_hold1", 32'(grant), 32'(cur));
      tick();
      check("rot_hold2", 32'(grant), 32'(cur));
      req = 4'b1111 & ~cur;
      tick();
      check_all("rot_dead", 4'b0000, 2'd0, 1'b0, 1'b0);
      req = 4'b1111;
      tick();
      check_all("rot_next", rot_seq[i], rot_idx[i], 1'b1, 1'b0);
      cur = rot_seq[i];
    end

    // Wrap and skip: get idx2 as owner, release with req=0011
    req = 4'b0100;
    tick();
    check("ws_dead0", 32'(grant), 32'h0);
    tick();
    check_all("ws_own2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0011;
    tick();
    check("ws_dead1", 32'(grant), 32'h0);
    tick();
    check_all("ws_wrap0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b1010;
    tick();
    check("ws_dead2", 32'(grant), 32'h0);
    tick();
    check_all("ws_ptr1", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Sole requester drops for one cycle and is re-granted
    req = 4'b0000;
    tick();
    check_all("sole_dead", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0010;
    tick();
    check_all("sole_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Timeout: idx0 holds, idx1 waits
    req = 4'b0000;
    tick();
    check("to_dead", 32'(grant), 32'h0);
    req = 4'b0001;
    tick();
    check_all("to_own0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0011;
`ifdef RR_GRANT_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("to_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    check_all("to_preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    check_all("to_next", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
    hold_ok = 1'b1;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (grant !== 4'b0001 || preempt !== 1'b0) hold_ok = 1'b0;
    end
    check("to_unbounded", 32'(hold_ok), 32'd1);
    check_all("to_still", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

    // Mid-tenure reset while idx2 owns
    req = 4'b0100;
    tick();
    check("mr_dead", 32'(grant), 32'h0);
    tick();
    check_all("mr_own2", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_all("mr_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("mr_rst.idx", 32'(grant_idx), 32'd0);
    rst = 1'b0;
    req = 4'b1100;
    tick();
    check_all("mr_after", 4'b0100, 2'd2, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin arbiter that shares one downstream resource among `1<<BITS` requesters. It issues a registered one-hot grant and the matching binary index, holds the grant for the owner's full tenure, and inserts one dead cycle between owners for resource turnaround. It sits in front of any shared datapath whose select lines are driven one-hot from a binary code.

## Interface
- `BITS`, default 3: requester index width; N = `1<<BITS` requesters.
- `HOLD_MAX`, default 16: maximum tenure in grant cycles. Used only when `RR_GRANT_TIMEOUT_EN` is defined; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input N: per-requester request level; bit i high means requester i wants or holds the resource.
- `grant` output N: one-hot grant, or all zero when no owner; registered.
- `grant_idx` output BITS: binary index of the current owner; valid only while `grant_valid` is high.
- `grant_valid` output 1: high while any grant bit is set.
- `preempt` output 1: one-cycle pulse when a tenure is ended by timeout (always 0 without the macro).

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner = `grant_idx`.
- Pointer `ptr` (BITS wide) marks the highest-priority index for the next arbitration.
- Priority search is circular: ptr, ptr+1, …, N-1, 0, …, ptr-1, with mod-N wrap-around.
- IDLE:
  - If `req` is nonzero, latch the first set bit in circular order as owner and go to GRANT.
  - If `req` is zero, stay in IDLE.
- GRANT:
  - While `req[grant_idx]` is high, hold the owner. Other requests are ignored (no mid-tenure preemption unless the timeout fires).
  - When `req[grant_idx]` is low, go to IDLE with grant cleared, and set ptr = `grant_idx`+1 mod N.
- `grant` is always the one-hot decode of `grant_idx`, gated by `grant_valid`. It never has more than one bit set.
- Requests from non-owners may toggle freely; they are sampled only in IDLE.
- Simultaneous events:
  - The owner drops and re-raises `req` in consecutive cycles, with no other requesters: it is re-granted after the dead cycle (ptr wraps back to it).
  - The owner drops while others request: the next winner follows circular order from the new ptr.
- Reset: `grant`=0, `grant_idx`=0, `grant_valid`=0, `preempt`=0, ptr=0, state IDLE, tenure counter=0.
- Reset asserted mid-tenure clears the grant at that same edge, with no completion of the tenure.

## Timing
- Request to grant: a req rising at edge k while in IDLE gives `grant` high after edge k+1 (1-cycle latency).
- Release: owner `req` low sampled at edge t gives `grant`=0 after t. The earliest next grant appears after t+1, so exactly one dead cycle separates owners.
- `grant`, `grant_idx` and `grant_valid` change on the same edge; there are no combinational paths from `req` to the outputs.
- `preempt` is high for exactly the first IDLE cycle following a forced release.

## Configuration
- `RR_GRANT_TIMEOUT_EN` defined:
  - An 8-bit tenure counter clears on entry to GRANT and increments each GRANT cycle.
  - Once the owner has held the grant for `HOLD_MAX` cycles and any other `req` bit is set, force IDLE, set ptr = owner+1, and pulse `preempt`.
  - A sole requester is never preempted; the counter saturates.
- Not defined: no counter, `preempt` is tied 0, `HOLD_MAX` is ignored, and tenure is unbounded.

## Structure
- Shared package `rr_grant_pkg`: state encodings (IDLE=1'b0, GRANT=1'b1) and a circular-priority-pick function `(req, ptr) -> idx, found`.
- One sub-module, `decoder` (BITS-parameterised binary-to-one-hot), drives `grant` from `grant_idx`.
- The FSM, pointer and counter stay in the top module.

## Test plan
All scenarios use BITS=2, N=4.
- Reset: `rst`=1 for 2 cycles with `req`=4'b1111 → outputs stay 0. One cycle after `rst` falls, `grant`=4'b0001 and `grant_idx`=0.
- Rotation: `req`=4'b1111, each owner drops req 3 cycles after its grant and then re-raises it → grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one all-zero cycle between each.
- Wrap and skip: idx2 releases (ptr=3), then `req`=4'b0011 → next grant 4'b0001, and ptr=1 afterwards.
- Sole requester re-grant: only idx1 requests; it drops req for 1 cycle and re-raises → `grant`=4'b0010 again after the single dead cycle.
- Timeout (macro on, HOLD_MAX=4): idx0 holds req, idx1 requests → 4'b0001 for exactly 4 cycles, then `preempt` pulses 1 cycle with `grant`=0, then 4'b0010. With the macro off, 4'b0001 persists for 100+ cycles.
- Mid-tenure reset: `rst` during `grant`=4'b0100 → next edge `grant`=0. After release of `rst` with `req`=4'b1100, the grant goes to idx2 because ptr was reset to 0.
